// File: rtl/dfx_rp_seq.sv
// dfx_rp_seq: round-robin partial-reconfiguration sequencer with per-RP decouple, reset and LED gating
module dfx_rp_seq #(
  parameter int N_RP         = 2,
  parameter int DECOUPLE_CYC = 4,
  parameter int RST_HOLD     = 16,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic            clk100,
  input  logic            rstn,
  input  logic [N_RP-1:0] pr_req_i,
  output logic [N_RP-1:0] pr_ack_o,
  output logic            cfg_start_o,
  output logic            cfg_sel_o,
  input  logic            cfg_done_i,
  input  logic            cfg_err_i,
  input  logic            err_clr_i,
  output logic [N_RP-1:0] decouple_o,
  output logic [N_RP-1:0] rp_rst_o,
  input  logic [N_RP-1:0] leds_i,
  output logic [N_RP-1:0] leds_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEC    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_RECPL  = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;
  logic [2:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_sel, r_ptr, r_start, r_done, r_err;
  logic [N_RP-1:0] r_ack, r_dec, r_rst, r_leds;
  logic            w_gsel;
  // r_ptr holds the RP with priority for the next grant
  assign w_gsel      = pr_req_i[r_ptr] ? r_ptr : ~r_ptr;
  assign busy_o      = r_state != S_IDLE;
  assign cfg_sel_o   = r_sel;
  assign pr_ack_o    = r_ack;
  assign cfg_start_o = r_start;
  assign decouple_o  = r_dec;
  assign rp_rst_o    = r_rst;
  assign leds_o      = r_leds;
  assign done_o      = r_done;
  assign err_o       = r_err;
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_ptr   <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ack   <= '0;
      r_dec   <= '0;
      r_rst   <= '0;
      r_leds  <= '0;
    end else begin
      r_ack   <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_leds  <= leds_i & ~r_dec;
      case (r_state)
        S_IDLE: if (|pr_req_i) begin
          r_sel          <= w_gsel;
          r_ack[w_gsel]  <= 1'b1;
          r_dec[w_gsel]  <= 1'b1;
          r_cnt          <= '0;
          r_state        <= S_DEC;
        end
        S_DEC: if (r_cnt >= CW'(DECOUPLE_CYC)) begin
          r_rst[r_sel] <= 1'b1;
          r_start      <= 1'b1;
          r_cnt        <= '0;
          r_state      <= S_LOAD;
        end else r_cnt <= r_cnt + CW'(1);
        // error beats a simultaneous done; a done on the last cycle beats the timeout
        S_LOAD: if (cfg_err_i) begin
          r_err   <= 1'b1;
          r_state <= S_FAULT;
        end else if (cfg_done_i) begin
          r_cnt <= '0;
          if (RST_HOLD > 1) r_state <= S_SETTLE;
          else begin
            r_rst[r_sel] <= 1'b0;
            r_state      <= S_RECPL;
          end
        end else if (r_cnt >= CW'(TIMEOUT_CYC - 1)) begin
          r_err   <= 1'b1;
          r_state <= S_FAULT;
        end else r_cnt <= r_cnt + CW'(1);
        S_SETTLE: if (r_cnt >= CW'(RST_HOLD - 2)) begin
          r_rst[r_sel] <= 1'b0;
          r_cnt        <= '0;
          r_state      <= S_RECPL;
        end else r_cnt <= r_cnt + CW'(1);
        S_RECPL: if (r_cnt >= CW'(DECOUPLE_CYC - 1)) begin
          r_dec[r_sel] <= 1'b0;
          r_done       <= 1'b1;
          r_ptr        <= ~r_sel;
          r_state      <= S_IDLE;
        end else r_cnt <= r_cnt + CW'(1);
        // decouple/reset of the failed RP stay set until it reloads successfully
        S_FAULT: if (err_clr_i) begin
          r_err   <= 1'b0;
          r_ptr   <= ~r_sel;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dfx_rp_seq.sv
// tb_dfx_rp_seq: randomized scoreboard bench for the reconfiguration sequencer
module tb_dfx_rp_seq;
  localparam int OK = 0, ERR = 1, BOTH = 2, TMO = 3;
  localparam int E_ACK = 0, E_START = 1, E_RSTF = 2, E_DONE = 3, E_ERR = 4;
  typedef struct { int kind; logic [3:0] val; int off; } exp_t;
  logic clk100, rstn, cfg_start_o, cfg_sel_o, cfg_done_i, cfg_err_i, err_clr_i, busy_o, done_o, err_o;
  logic [1:0] pr_req_i, pr_ack_o, decouple_o, rp_rst_o, leds_i, leds_o;
  exp_t sbq[$];
  int n_chk, n_fail, cyc, last_cyc, ptr;
  logic [1:0] req, quar;
  bit abort;
  dfx_rp_seq #(.N_RP(2), .DECOUPLE_CYC(4), .RST_HOLD(16), .TIMEOUT_CYC(100)) dut (
    .clk100(clk100), .rstn(rstn), .pr_req_i(pr_req_i), .pr_ack_o(pr_ack_o),
    .cfg_start_o(cfg_start_o), .cfg_sel_o(cfg_sel_o), .cfg_done_i(cfg_done_i),
    .cfg_err_i(cfg_err_i), .err_clr_i(err_clr_i), .decouple_o(decouple_o),
    .rp_rst_o(rp_rst_o), .leds_i(leds_i), .leds_o(leds_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );
  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk100);
      cyc++;
    end
  end
  initial begin
    leds_i = 2'b00;
    forever begin
      @(posedge clk100);
      #2 leds_i = 2'($urandom);
    end
  end
  function automatic logic [1:0] onehot(input int g);
    return (g != 0) ? 2'b10 : 2'b01;
  endfunction
  // round-robin: first requesting RP at or after the priority pointer
  function automatic int rr_pick(input logic [1:0] r, input int p);
    for (int k = 0; k < 2; k++)
      if (((r >> ((p + k) % 2)) & 2'b01) != 2'b00) return (p + k) % 2;
    return p;
  endfunction
  function automatic logic [15:0] all_outs();
    return 16'({pr_ack_o, cfg_start_o, cfg_sel_o, decouple_o, rp_rst_o, leds_o, busy_o, done_o, err_o});
  endfunction
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask
  task automatic ev(input int k, input logic [3:0] v);
    exp_t e;
    n_chk++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event at cycle %0d: kind %0d val %h, scoreboard empty", cyc, k, v);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k || e.val !== v || (e.off >= 0 && cyc - last_cyc != e.off)) begin
        n_fail++;
        $display("FAIL event at cycle %0d: got kind %0d val %h offset %0d, expected kind %0d val %h offset %0d",
                 cyc, k, v, cyc - last_cyc, e.kind, e.val, e.off);
      end
    end
    last_cyc = cyc;
  endtask
  // monitor: LED gating every cycle plus scoreboard events
  initial begin
    logic [1:0] cap, prst;
    logic perr;
    bit lv;
    lv = 0; cap = 2'b00; prst = 2'b00; perr = 1'b0;
    forever begin
      @(negedge clk100);
      if (!rstn) begin
        lv = 0; prst = 2'b00; perr = 1'b0;
      end else begin
        if (lv) chk("leds_gate", 16'(leds_o), 16'(cap));
        cap = leds_i & ~decouple_o;
        lv = 1;
        if (|pr_ack_o) ev(E_ACK, {2'b00, pr_ack_o});
        if (cfg_start_o) ev(E_START, {1'b0, decouple_o, cfg_sel_o});
        if (|(prst & ~rp_rst_o)) ev(E_RSTF, {2'b00, prst & ~rp_rst_o});
        if (done_o) ev(E_DONE, {decouple_o, rp_rst_o});
        if (err_o && !perr) ev(E_ERR, {decouple_o, rp_rst_o});
        prst = rp_rst_o;
        perr = err_o;
      end
    end
  end
  task automatic wait_for(input int w, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk100);
      ok = (w == 0) ? |pr_ack_o : (w == 1) ? cfg_start_o : (w == 2) ? done_o : err_o;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      abort = 1;
      $display("FAIL wait_%0d: no response within %0d cycles", w, lim);
    end
  endtask
  task automatic run_job(input logic [1:0] add, input int outc, input int lat);
    int g;
    logic [1:0] m;
    bit ok;
    if (abort) return;
    req |= add;
    if (req == 2'b00) req = 2'b01;
    g = rr_pick(req, ptr);
    m = onehot(g);
    sbq.push_back('{E_ACK, {2'b00, m}, -1});
    sbq.push_back('{E_START, {1'b0, quar | m, g[0]}, 5});
    if (outc == OK) begin
      sbq.push_back('{E_RSTF, {2'b00, m}, lat + 16});
      sbq.push_back('{E_DONE, {quar & ~m, quar & ~m}, 4});
    end else sbq.push_back('{E_ERR, {quar | m, quar | m}, (outc == TMO) ? 100 : lat + 1});
    pr_req_i = req;
    wait_for(0, 40, ok);
    if (!ok) return;
    req &= ~pr_ack_o;
    pr_req_i = req;
    wait_for(1, 40, ok);
    if (!ok) return;
    if (outc != TMO) begin
      repeat (lat) @(negedge clk100);
      cfg_done_i = (outc != ERR);
      cfg_err_i = (outc != OK);
      @(negedge clk100);
      cfg_done_i = 1'b0;
      cfg_err_i = 1'b0;
    end
    if (outc == OK) begin
      wait_for(2, 200, ok);
      if (!ok) return;
      quar &= ~m;
    end else begin
      wait_for(3, 200, ok);
      if (!ok) return;
      repeat ($urandom_range(0, 3)) @(negedge clk100);
      chk("fault_hold", 16'({busy_o, err_o}), 16'h0003);
      err_clr_i = 1'b1;
      @(negedge clk100);
      err_clr_i = 1'b0;
      quar |= m;
      chk("fault_clear", 16'({decouple_o, rp_rst_o, err_o, busy_o}), 16'({quar, quar, 2'b00}));
    end
    ptr = (g + 1) % 2;
  endtask
  task automatic stray_idle();
    if (abort) return;
    cfg_done_i = 1'b1; cfg_err_i = 1'b1; err_clr_i = 1'b1;
    @(negedge clk100);
    cfg_done_i = 1'b0; cfg_err_i = 1'b0; err_clr_i = 1'b0;
    repeat (2) @(negedge clk100);
    chk("stray_idle", 16'({pr_ack_o, cfg_start_o, busy_o, done_o, err_o, decouple_o, rp_rst_o}),
        16'({6'b000000, quar, quar}));
  endtask
  initial begin
    bit ok;
    int o;
    n_chk = 0; n_fail = 0; last_cyc = 0; ptr = 0; req = 2'b00; quar = 2'b00; abort = 0;
    rstn = 1'b0; pr_req_i = 2'b00; cfg_done_i = 1'b0; cfg_err_i = 1'b0; err_clr_i = 1'b0;
    repeat (3) @(posedge clk100);
    #1 chk("reset_state", all_outs(), 16'h0000);
    @(posedge clk100);
    #3 rstn = 1'b1;
    @(negedge clk100);
    run_job(2'b11, OK, 50);
    run_job(2'b00, OK, 5);
    run_job(2'b11, OK, 7);
    run_job(2'b00, OK, 9);
    run_job(2'b01, OK, 50);
    stray_idle();
    run_job(2'b10, ERR, 20);
    run_job(2'b01, OK, 3);
    run_job(2'b10, OK, 8);
    run_job(2'b01, TMO, 0);
    run_job(2'b10, BOTH, 12);
    for (int i = 0; i < 14; i++) begin
      o = int'($urandom_range(0, 5));
      run_job(2'($urandom_range(0, 3)), (o < 3) ? OK : o - 2, int'($urandom_range(0, 60)));
    end
    while (req != 2'b00 && !abort) run_job(2'b00, OK, 2);
    run_job(2'b01, OK, 4);
    if (!abort) begin
      // interrupt an RP0 load during the reset-hold phase
      req = 2'b01;
      sbq.push_back('{E_ACK, 4'b0001, -1});
      sbq.push_back('{E_START, {1'b0, quar | 2'b01, 1'b0}, 5});
      pr_req_i = req;
      wait_for(0, 40, ok);
      req = 2'b00;
      pr_req_i = req;
      if (ok) wait_for(1, 40, ok);
      if (ok) begin
        repeat (3) @(negedge clk100);
        cfg_done_i = 1'b1;
        @(negedge clk100);
        cfg_done_i = 1'b0;
        repeat (5) @(negedge clk100);
        @(posedge clk100);
        #2 rstn = 1'b0;
        #1 chk("async_reset", all_outs(), 16'h0000);
        sbq.delete();
        quar = 2'b00;
        ptr = 0;
        repeat (2) @(posedge clk100);
        #3 rstn = 1'b1;
        @(negedge clk100);
      end
    end
    run_job(2'b11, OK, 5);
    run_job(2'b00, OK, 6);
    repeat (10) @(negedge clk100);
    chk("scoreboard_empty", 16'(sbq.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dfx_rp_seq.md
Name: dfx_rp_seq

Overview:
- Reconfiguration sequencer for the two LED-counter reconfigurable partitions (RP0 = led_cnt_pr, RP1 = led_cnt2_pr) in the led_cnt top.
- Arbitrates reconfiguration requests from software/GPIO. Only one partial-bitstream load is in flight at a time.
- Per RP it sequences decouple -> RP reset -> configuration-engine start -> settle -> recouple.
- Gates RP LED outputs to 0 while an RP is decoupled. An RP whose load failed stays quarantined.

Parameters:
- N_RP, 2, number of reconfigurable partitions; this spec fixes it at 2.
- DECOUPLE_CYC, 4, cycles decouple is held before the RP reset/load starts; also the cycles held after reset release. Minimum 1.
- RST_HOLD, 16, cycles the RP reset stays asserted after cfg_done_i. Minimum 1.
- TIMEOUT_CYC, 1000000, maximum cycles waited in LOAD for cfg_done_i/cfg_err_i.

Ports:
- clk100  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- pr_req_i  in  N_RP  level reconfig request per RP; held until the matching pr_ack_o.
- pr_ack_o  out  N_RP  one-cycle grant pulse.
- cfg_start_o  out  1  one-cycle pulse to the configuration engine (ICAP/PCAP driver).
- cfg_sel_o  out  1  index of the RP being loaded; valid while busy_o.
- cfg_done_i  in  1  one-cycle pulse: load succeeded.
- cfg_err_i  in  1  one-cycle pulse: load failed.
- err_clr_i  in  1  one-cycle pulse: leave FAULT.
- decouple_o  out  N_RP  per-RP decouple.
- rp_rst_o  out  N_RP  per-RP reset (active-high), ORed with ~rstn at the top.
- leds_i  in  N_RP  raw LED outputs from the RPs.
- leds_o  out  N_RP  gated LED outputs.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse on successful recouple.
- err_o  out  1  sticky, set on load error or timeout.

Behaviour:
- Reset (rstn low, async):
  - State IDLE; all outputs 0; round-robin pointer = 0; counters = 0.
  - Aborts any sequence in progress; the configuration engine is not notified.
- State IDLE:
  - Any pr_req_i bit set -> grant round-robin, starting at (last grant + 1) mod N_RP; after reset RP0 has priority.
  - Latch sel; pulse pr_ack_o[sel]; set decouple_o[sel]; counter = 0 -> DECOUPLE.
- State DECOUPLE:
  - Count DECOUPLE_CYC cycles.
  - On expiry: set rp_rst_o[sel], pulse cfg_start_o, counter = 0 -> LOAD.
  - cfg_start_o therefore rises exactly DECOUPLE_CYC+1 cycles after pr_ack_o.
- State LOAD:
  - Counter increments each cycle.
  - cfg_err_i -> FAULT.
  - Counter reaching TIMEOUT_CYC-1 with no response -> FAULT.
  - cfg_done_i -> SETTLE, counter = 0.
  - cfg_done_i and cfg_err_i in the same cycle: error wins.
- State SETTLE:
  - Hold rp_rst_o[sel] for RST_HOLD cycles, then clear it; counter = 0 -> RECOUPLE.
- State RECOUPLE:
  - Hold decouple_o[sel] for DECOUPLE_CYC cycles, then clear it.
  - Pulse done_o; update the round-robin pointer -> IDLE.
- State FAULT:
  - err_o = 1; decouple_o[sel] and rp_rst_o[sel] stay set (quarantine) until a later successful sequence on that RP.
  - err_clr_i clears err_o -> IDLE. The pointer still advances.
  - A later request for a quarantined RP is accepted normally.
- Out-of-state inputs:
  - cfg_done_i/cfg_err_i outside LOAD: ignored.
  - err_clr_i outside FAULT: ignored.
  - pr_req_i outside IDLE: not acknowledged; remains pending.
- Non-selected RP: its decouple_o/rp_rst_o bits are never changed by the sequence.
- LED gating:
  - leds_o[i] is registered: leds_o[i] <= decouple_o[i] ? 0 : leds_i[i].
  - One cycle latency; 0 in reset.
- Counters: width $clog2(TIMEOUT_CYC+1); no wrap, saturating compare.
- busy_o is combinational from the state register (state != IDLE).

Test Plan:
- Single request, success:
  - Stimulus: pr_req_i=01; cfg_done_i 50 cycles after cfg_start_o.
  - Response: pr_ack_o=01, then cfg_start_o 5 cycles later with cfg_sel_o=0. rp_rst_o[0] falls 16 cycles after done; decouple_o[0] falls 4 cycles after that; done_o pulses.
  - leds_o[0]=0 throughout; leds_o[1] follows leds_i[1].
- Simultaneous requests:
  - Stimulus: pr_req_i=11 held.
  - Response: RP0 serviced first, then RP1. Never both decouple bits set by one sequence. Repeat -> RP0 again only after RP1.
- Load error:
  - Stimulus: cfg_err_i during RP1 LOAD.
  - Response: err_o=1, FAULT, decouple_o[1]=rp_rst_o[1]=1 held.
  - After err_clr_i: IDLE, bits still set. A new RP1 request with success clears both bits.
- Timeout:
  - Stimulus: TIMEOUT_CYC=100, no response.
  - Response: FAULT exactly 100 cycles after the cfg_start_o cycle; err_o=1.
- Done and error together:
  - Stimulus: cfg_done_i and cfg_err_i asserted in the same cycle.
  - Response: FAULT. Also: a stray cfg_done_i in IDLE causes no output change.
- Mid-operation reset:
  - Stimulus: rstn low during SETTLE.
  - Response: all outputs 0 asynchronously, before the next clk100 edge; IDLE after release; RP0 has priority.
